multi_blinker: RTL and testbench

Parametrised multi-channel blink/pulse generator for board LEDs and header pins, replacing a single shared toggle. Each channel has its own period counter and runtime-selectable mode: off, toggle, PWM or one-shot. Channels are configured through a simple write port. Out of reset, every channel toggles at a default rate.

---
 rtl/multi_blinker_pkg.sv | 14 +
 rtl/blink_channel.sv | 84 ++++++++
 rtl/multi_blinker.sv | 44 ++++
 tb/tb_multi_blinker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_blinker_pkg.sv
// Shared types and reset defaults for the multi-channel blink/pulse generator.
package multi_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam int unsigned DEF_PERIOD = 10_000_000;
  localparam int unsigned DEF_DUTY   = DEF_PERIOD / 2;

endpackage

// File: rtl/blink_channel.sv
// One blinker channel: config registers, period counter, mode FSM, registered out/tick.
//
// state        | meaning
// MODE_OFF     | counter parked at 0, out and tick held low
// MODE_TOGGLE  | out inverts at every period wrap (square wave, period 2P)
// MODE_PWM     | out high while count < duty
// MODE_ONESHOT | out high for P cycles, then falls back to MODE_OFF
module blink_channel
  import multi_blinker_pkg::*;
#(
  parameter int unsigned      CNT_W      = 24,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD),
  parameter logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEF_DUTY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  mode_e            i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_out,
  output logic             o_tick
);

  mode_e            r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_tick;

  logic [CNT_W-1:0] w_p;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A programmed period of 0 behaves as 1 so the counter always has a valid range.
  assign w_p       = (r_period == '0) ? CNT_W'(1) : r_period;
  assign w_wrap    = (r_cnt == (w_p - CNT_W'(1)));
  assign w_cnt_nxt = ((r_mode == MODE_OFF) || w_wrap) ? '0 : (r_cnt + CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= MODE_TOGGLE;
      r_period <= RST_PERIOD;
      r_duty   <= RST_DUTY;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else if (i_we) begin
      // A write overrides any wrap landing on the same edge.
      r_mode   <= i_mode;
      r_period <= i_period;
      r_duty   <= i_duty;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      unique case (i_mode)
        MODE_ONESHOT: r_out <= 1'b1;
        MODE_PWM:     r_out <= (i_duty != '0);
        MODE_TOGGLE:  r_out <= 1'b0;
        MODE_OFF:     r_out <= 1'b0;
      endcase
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (r_mode != MODE_OFF) && w_wrap;
      unique case (r_mode)
        MODE_OFF: r_out <= 1'b0;
        MODE_TOGGLE: begin
          if (w_wrap) r_out <= ~r_out;
        end
        MODE_PWM: r_out <= (w_cnt_nxt < r_duty);
        MODE_ONESHOT: begin
          if (w_wrap) begin
            r_out  <= 1'b0;
            r_mode <= MODE_OFF;
          end
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_tick = r_tick;

endmodule

// File: rtl/multi_blinker.sv
// Multi-channel blink/pulse generator: config write decode plus CHANNELS
// independent blink_channel instances.
module multi_blinker
  import multi_blinker_pkg::*;
#(
  parameter  int unsigned CHANNELS       = 5,
  parameter  int unsigned CNT_W          = 24,
  parameter  int unsigned DEFAULT_PERIOD = DEF_PERIOD,
  parameter  int unsigned DEFAULT_DUTY   = DEFAULT_PERIOD / 2,
  localparam int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);

  // Indices at or above CHANNELS match no instance, so such writes are dropped.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic w_we;
    assign w_we = cfg_we && (cfg_ch == CH_W'(gi));

    blink_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (CNT_W'(DEFAULT_PERIOD)),
      .RST_DUTY   (CNT_W'(DEFAULT_DUTY))
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_we),
      .i_mode   (mode_e'(cfg_mode)),
      .i_period (cfg_period),
      .i_duty   (cfg_duty),
      .o_out    (out[gi]),
      .o_tick   (tick[gi])
    );
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker with a closed-form per-channel model feeding a scoreboard.
module tb_multi_blinker;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clk;
  logic           rst_n;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [1:0]     cfg_mode;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_duty;
  logic [NCH-1:0] w_out;
  logic [NCH-1:0] w_tick;

  multi_blinker #(
    .CHANNELS       (NCH),
    .CNT_W          (CW),
    .DEFAULT_PERIOD (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .out        (w_out),
    .tick       (w_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    int             cyc;
    logic [NCH-1:0] o;
    logic [NCH-1:0] t;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string cur_tag = "reset";

  // Per-channel configuration as seen by the model; s = first cycle of the config.
  int d_mode [NCH];
  int d_s    [NCH];
  int d_p    [NCH];
  int d_duty [NCH];

  task automatic set_defaults();
    for (int i = 0; i < NCH; i++) begin
      d_mode[i] = 1; d_s[i] = 0; d_p[i] = 4; d_duty[i] = 2;
    end
  endtask

  function automatic exp_t model(input int c);
    exp_t e;
    e.tag = cur_tag;
    e.cyc = c;
    e.o   = '0;
    e.t   = '0;
    for (int i = 0; i < NCH; i++) begin
      int j, p;
      j = c - d_s[i];
      p = d_p[i];
      case (d_mode[i])
        1: begin e.o[i] = ((j / p) % 2) == 1; e.t[i] = (j > 0) && (j % p == 0); end
        2: begin e.o[i] = (j % p) < d_duty[i]; e.t[i] = (j > 0) && (j % p == 0); end
        3: begin e.o[i] = (j < p);             e.t[i] = (j == p);                end
        default: begin e.o[i] = 1'b0; e.t[i] = 1'b0; end
      endcase
    end
    return e;
  endfunction

  task automatic compare();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty cyc=%0d", cyc);
      return;
    end
    e = q.pop_front();
    checks++;
    assert (w_out === e.o) else begin
      errors++;
      $error("FAIL %s cyc=%0d out=%b expected=%b", e.tag, e.cyc, w_out, e.o);
    end
    checks++;
    assert (w_tick === e.t) else begin
      errors++;
      $error("FAIL %s cyc=%0d tick=%b expected=%b", e.tag, e.cyc, w_tick, e.t);
    end
  endtask

  task automatic cycle();
    q.push_back(model(cyc + 1));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    cyc++;
    compare();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wr(input int ch, input int mode, input int per, input int duty);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CW'(per);
    cfg_duty   = CW'(duty);
    if (ch < NCH) begin
      d_mode[ch] = mode;
      d_s[ch]    = cyc + 1;
      d_p[ch]    = (per == 0) ? 1 : per;
      d_duty[ch] = duty;
    end
    cycle();
  endtask

  task automatic push_zero(input string tag);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc;
    e.o   = '0;
    e.t   = '0;
    q.push_back(e);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_period = '0;
    cfg_duty   = '0;
    set_defaults();

    repeat (2) @(posedge clk);
    #2;
    push_zero("in_reset");
    compare();
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    cur_tag = "reset_default";
    q.push_back(model(0));
    compare();
    cycles(12);

    cur_tag = "pwm_p8_d3";
    wr(1, 2, 8, 3);
    cycles(24);

    cur_tag = "bad_channel";
    wr(3, 3, 2, 0);
    cycles(8);

    cur_tag = "oneshot_p5";
    wr(0, 3, 5, 0);
    cycles(60);

    cur_tag = "period0_pwm_d0";
    wr(2, 1, 0, 0);
    wr(1, 2, 8, 0);
    cycles(16);

    cur_tag = "pwm_d9_p8";
    wr(1, 2, 8, 9);
    cycles(16);

    // ch0 toggle with out low, then rewrite exactly on its wrap cycle
    cur_tag = "wrap_write";
    wr(0, 1, 4, 0);
    cycles(3);
    wr(0, 1, 4, 0);
    cycles(10);

    cur_tag = "pre_async_rst";
    wr(0, 3, 20, 0);
    wr(1, 2, 8, 5);
    cycles(3);
    #3;
    rst_n = 1'b0;
    #1;
    push_zero("async_rst");
    compare();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = 0;
    set_defaults();
    cur_tag = "post_rst";
    q.push_back(model(0));
    compare();
    cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
